// File: rtl/dsp_pkg.sv
// Shared definitions for the time-multiplexed stereo voice mixer.
//
// Contents:
//   state_t       - sample schedule states (IDLE, ACCUM, MASTER, OUTPUT)
//   MVOL_SHIFT    - arithmetic shift applied before and after the master/echo
//                   volume multiply
//   DEF_*         - default widths; DEF_SAMPLE_W is also the clamp width used
//                   by every mix channel (main and echo alike)
package dsp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    MASTER = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  localparam int MVOL_SHIFT = 7;

  localparam int DEF_N_VOICES          = 8;
  localparam int DEF_SAMPLE_W          = 16;
  localparam int DEF_VOL_W             = 8;
  localparam int DEF_ACC_W             = 32;
  localparam int DEF_CLOCKS_PER_SAMPLE = 64;

endpackage

// File: rtl/dsp_voice_mixer_if.sv
// Bus between the voice decoders / register file and the mixer.
//
// Signals:
//   voice_sample          signed samples, voice v at [v*SAMPLE_W +: SAMPLE_W]
//   voice_vol_l/_r        signed per-voice volumes, voice v at [v*VOL_W +: VOL_W]
//   main_vol_l/_r         signed master volumes
//   echo_vol_l/_r         signed echo-send volumes
//   eon                   per-voice echo enable
//   mute                  silences the main (DAC) outputs only
//   dac_out_l/_r          mixed main output
//   echo_out_l/_r         echo send output
//   sample_strobe         one-cycle pulse when the outputs update
//   busy                  mixer is working through a sample
// Modports: master drives the inputs and reads results, slave is the mixer.
interface dsp_voice_mixer_if
  import dsp_pkg::*;
#(
  parameter int N_VOICES = DEF_N_VOICES,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int VOL_W    = DEF_VOL_W
);

  logic [N_VOICES*SAMPLE_W-1:0] voice_sample;
  logic [N_VOICES*VOL_W-1:0]    voice_vol_l;
  logic [N_VOICES*VOL_W-1:0]    voice_vol_r;
  logic signed [VOL_W-1:0]      main_vol_l;
  logic signed [VOL_W-1:0]      main_vol_r;
  logic signed [VOL_W-1:0]      echo_vol_l;
  logic signed [VOL_W-1:0]      echo_vol_r;
  logic [N_VOICES-1:0]          eon;
  logic                         mute;
  logic signed [SAMPLE_W-1:0]   dac_out_l;
  logic signed [SAMPLE_W-1:0]   dac_out_r;
  logic signed [SAMPLE_W-1:0]   echo_out_l;
  logic signed [SAMPLE_W-1:0]   echo_out_r;
  logic                         sample_strobe;
  logic                         busy;

  modport master (
    output voice_sample, voice_vol_l, voice_vol_r,
    output main_vol_l, main_vol_r, echo_vol_l, echo_vol_r,
    output eon, mute,
    input  dac_out_l, dac_out_r, echo_out_l, echo_out_r,
    input  sample_strobe, busy
  );

  modport slave (
    input  voice_sample, voice_vol_l, voice_vol_r,
    input  main_vol_l, main_vol_r, echo_vol_l, echo_vol_r,
    input  eon, mute,
    output dac_out_l, dac_out_r, echo_out_l, echo_out_r,
    output sample_strobe, busy
  );

endinterface

// File: rtl/dsp_mix_channel.sv
// One mixer output channel: voice MAC accumulator, master/echo volume
// multiply and saturating clamp onto a registered output.
//
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   clear          zero the accumulator (start of a sample)
//   acc_en         accumulate the current voice product this cycle
//   enable         per-voice gate (eon for echo channels, tied high for main)
//   master_en      latch the master-volume scaled result
//   out_en         clamp and register the result onto out
//   force_zero     register zero instead of the clamped result (mute)
//   sample, vol    current voice sample and its volume
//   master_vol     master or echo volume for this channel
//   out            registered, clamped channel output
module dsp_mix_channel
  import dsp_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int VOL_W    = DEF_VOL_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       acc_en,
  input  logic                       enable,
  input  logic                       master_en,
  input  logic                       out_en,
  input  logic                       force_zero,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic signed [VOL_W-1:0]    vol,
  input  logic signed [VOL_W-1:0]    master_vol,
  output logic signed [SAMPLE_W-1:0] out
);

  localparam int PROD_W = SAMPLE_W + VOL_W;
  localparam int MAST_W = ACC_W + VOL_W;
  localparam logic signed [MAST_W-1:0] SAT_MAX =
    {{(MAST_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [MAST_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [MAST_W-1:0]   mast_q, mast_d;
  logic signed [SAMPLE_W-1:0] out_q, out_d;
  logic signed [PROD_W-1:0]   voice_prod;
  logic signed [ACC_W-1:0]    acc_shift;
  logic signed [MAST_W-1:0]   mast_prod;
  logic signed [SAMPLE_W-1:0] clamped;

  always_comb begin
    // Operands are sign-extended to the product width so the multiply is
    // full precision; -128 volumes are handled like any other value.
    voice_prod = $signed({{VOL_W{sample[SAMPLE_W-1]}}, sample}) *
                 $signed({{SAMPLE_W{vol[VOL_W-1]}}, vol});
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (acc_en && enable) begin
      acc_d = acc_q + {{(ACC_W-PROD_W){voice_prod[PROD_W-1]}}, voice_prod};
    end

    acc_shift = acc_q >>> MVOL_SHIFT;
    mast_prod = $signed({{VOL_W{acc_shift[ACC_W-1]}}, acc_shift}) *
                $signed({{ACC_W{master_vol[VOL_W-1]}}, master_vol});
    mast_d = master_en ? (mast_prod >>> MVOL_SHIFT) : mast_q;

    if (mast_q > SAT_MAX) begin
      clamped = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else if (mast_q < SAT_MIN) begin
      clamped = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      clamped = mast_q[SAMPLE_W-1:0];
    end

    out_d = out_q;
    if (out_en) begin
      out_d = force_zero ? '0 : clamped;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= '0;
      mast_q <= '0;
      out_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      mast_q <= mast_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/dsp_voice_mixer.sv
// Time-multiplexed stereo voice mixer. Once per sample period it snapshots
// all voice samples and volumes, accumulates one voice per clock into the
// main L/R and gated echo L/R channels, applies master/echo volume, clamps
// and presents the four results together with a one-cycle sample_strobe.
//
// Ports:
//   clock  system clock
//   reset  synchronous active-high reset; abandons a sample in progress
//   bus    dsp_voice_mixer_if slave modport (voice inputs, volumes, eon,
//          mute, the four outputs, sample_strobe, busy)
module dsp_voice_mixer
  import dsp_pkg::*;
#(
  parameter int N_VOICES          = DEF_N_VOICES,
  parameter int SAMPLE_W          = DEF_SAMPLE_W,
  parameter int VOL_W             = DEF_VOL_W,
  parameter int ACC_W             = DEF_ACC_W,
  parameter int CLOCKS_PER_SAMPLE = DEF_CLOCKS_PER_SAMPLE
) (
  input logic              clock,
  input logic              reset,
  dsp_voice_mixer_if.slave bus
);

  localparam int PW = (CLOCKS_PER_SAMPLE > 1) ? $clog2(CLOCKS_PER_SAMPLE) : 1;
  localparam int VW = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

  state_t                       state_q, state_d;
  logic [PW-1:0]                phase_q, phase_d;
  logic [VW-1:0]                v_q, v_d;
  logic                         strobe_q, strobe_d;
  logic                         snap_en, acc_en, master_en, out_en;

  logic [N_VOICES*SAMPLE_W-1:0] snap_sample_q, snap_sample_d;
  logic [N_VOICES*VOL_W-1:0]    snap_vol_l_q, snap_vol_l_d;
  logic [N_VOICES*VOL_W-1:0]    snap_vol_r_q, snap_vol_r_d;
  logic [VOL_W-1:0]             snap_main_l_q, snap_main_l_d;
  logic [VOL_W-1:0]             snap_main_r_q, snap_main_r_d;
  logic [VOL_W-1:0]             snap_echo_l_q, snap_echo_l_d;
  logic [VOL_W-1:0]             snap_echo_r_q, snap_echo_r_d;
  logic [N_VOICES-1:0]          snap_eon_q, snap_eon_d;
  logic                         snap_mute_q, snap_mute_d;

  logic [SAMPLE_W-1:0]          cur_sample;
  logic [VOL_W-1:0]             cur_vol_l, cur_vol_r;
  logic                         cur_eon;
  logic [SAMPLE_W-1:0]          dac_l, dac_r, echo_l, echo_r;

  // Schedule: free-running phase counter; the FSM leaves IDLE only at
  // phase 0 so the output period is locked to CLOCKS_PER_SAMPLE.
  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    snap_en   = 1'b0;
    acc_en    = 1'b0;
    master_en = 1'b0;
    out_en    = 1'b0;
    phase_d   = (phase_q == PW'(CLOCKS_PER_SAMPLE - 1)) ? '0 : phase_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (phase_q == '0) begin
          snap_en = 1'b1;
          v_d     = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_en = 1'b1;
        if (v_q == VW'(N_VOICES - 1)) begin
          state_d = MASTER;
        end else begin
          v_d = v_q + 1'b1;
        end
      end
      MASTER: begin
        master_en = 1'b1;
        state_d   = OUTPUT;
      end
      OUTPUT: begin
        out_en  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registered so the strobe rises on the same edge as the outputs.
    strobe_d = out_en;
  end

  // Input snapshot: later input changes cannot disturb a sample in flight.
  always_comb begin
    snap_sample_d = snap_sample_q;
    snap_vol_l_d  = snap_vol_l_q;
    snap_vol_r_d  = snap_vol_r_q;
    snap_main_l_d = snap_main_l_q;
    snap_main_r_d = snap_main_r_q;
    snap_echo_l_d = snap_echo_l_q;
    snap_echo_r_d = snap_echo_r_q;
    snap_eon_d    = snap_eon_q;
    snap_mute_d   = snap_mute_q;
    if (snap_en) begin
      snap_sample_d = bus.voice_sample;
      snap_vol_l_d  = bus.voice_vol_l;
      snap_vol_r_d  = bus.voice_vol_r;
      snap_main_l_d = bus.main_vol_l;
      snap_main_r_d = bus.main_vol_r;
      snap_echo_l_d = bus.echo_vol_l;
      snap_echo_r_d = bus.echo_vol_r;
      snap_eon_d    = bus.eon;
      snap_mute_d   = bus.mute;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      v_q           <= '0;
      strobe_q      <= 1'b0;
      snap_sample_q <= '0;
      snap_vol_l_q  <= '0;
      snap_vol_r_q  <= '0;
      snap_main_l_q <= '0;
      snap_main_r_q <= '0;
      snap_echo_l_q <= '0;
      snap_echo_r_q <= '0;
      snap_eon_q    <= '0;
      snap_mute_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      v_q           <= v_d;
      strobe_q      <= strobe_d;
      snap_sample_q <= snap_sample_d;
      snap_vol_l_q  <= snap_vol_l_d;
      snap_vol_r_q  <= snap_vol_r_d;
      snap_main_l_q <= snap_main_l_d;
      snap_main_r_q <= snap_main_r_d;
      snap_echo_l_q <= snap_echo_l_d;
      snap_echo_r_q <= snap_echo_r_d;
      snap_eon_q    <= snap_eon_d;
      snap_mute_q   <= snap_mute_d;
    end
  end

  assign cur_sample = snap_sample_q[v_q*SAMPLE_W +: SAMPLE_W];
  assign cur_vol_l  = snap_vol_l_q[v_q*VOL_W +: VOL_W];
  assign cur_vol_r  = snap_vol_r_q[v_q*VOL_W +: VOL_W];
  assign cur_eon    = snap_eon_q[v_q];

  dsp_mix_channel #(.SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W), .ACC_W(ACC_W)) u_main_l (
    .clock(clock), .reset(reset), .clear(snap_en), .acc_en(acc_en),
    .enable(1'b1), .master_en(master_en), .out_en(out_en),
    .force_zero(snap_mute_q), .sample(cur_sample), .vol(cur_vol_l),
    .master_vol(snap_main_l_q), .out(dac_l)
  );

  dsp_mix_channel #(.SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W), .ACC_W(ACC_W)) u_main_r (
    .clock(clock), .reset(reset), .clear(snap_en), .acc_en(acc_en),
    .enable(1'b1), .master_en(master_en), .out_en(out_en),
    .force_zero(snap_mute_q), .sample(cur_sample), .vol(cur_vol_r),
    .master_vol(snap_main_r_q), .out(dac_r)
  );

  // Echo send ignores mute; only the per-voice eon gate applies.
  dsp_mix_channel #(.SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W), .ACC_W(ACC_W)) u_echo_l (
    .clock(clock), .reset(reset), .clear(snap_en), .acc_en(acc_en),
    .enable(cur_eon), .master_en(master_en), .out_en(out_en),
    .force_zero(1'b0), .sample(cur_sample), .vol(cur_vol_l),
    .master_vol(snap_echo_l_q), .out(echo_l)
  );

  dsp_mix_channel #(.SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W), .ACC_W(ACC_W)) u_echo_r (
    .clock(clock), .reset(reset), .clear(snap_en), .acc_en(acc_en),
    .enable(cur_eon), .master_en(master_en), .out_en(out_en),
    .force_zero(1'b0), .sample(cur_sample), .vol(cur_vol_r),
    .master_vol(snap_echo_r_q), .out(echo_r)
  );

  assign bus.dac_out_l     = dac_l;
  assign bus.dac_out_r     = dac_r;
  assign bus.echo_out_l    = echo_l;
  assign bus.echo_out_r    = echo_r;
  assign bus.sample_strobe = strobe_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_dsp_voice_mixer.sv
// Self-checking bench for dsp_voice_mixer: directed cases (single voice,
// saturation, echo gating, mute, snapshot, reset mid-sample) followed by
// random mixes compared against an arithmetic reference model.
module tb_dsp_voice_mixer;

  localparam int NV  = 8;
  localparam int SW  = 16;
  localparam int VLW = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  dsp_voice_mixer_if bus ();

  dsp_voice_mixer dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int s[NV];
  int vl[NV];
  int vr[NV];
  int mvl, mvr, evl, evr;
  logic [NV-1:0] eonv;
  logic mutev;
  int exp_dl, exp_dr, exp_el, exp_er;
  int errors = 0;
  int checks = 0;
  int n;

  function automatic int clampS(longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  // Reference: sum of sample*volume products, then
  // floor(floor(acc/128) * vol / 128), clamped to 16 bits.
  task automatic computeModel();
    longint al, ar, el, er;
    al = 0; ar = 0; el = 0; er = 0;
    for (int v = 0; v < NV; v++) begin
      al += longint'(s[v]) * vl[v];
      ar += longint'(s[v]) * vr[v];
      if (eonv[v]) begin
        el += longint'(s[v]) * vl[v];
        er += longint'(s[v]) * vr[v];
      end
    end
    exp_dl = mutev ? 0 : clampS(((al >>> 7) * mvl) >>> 7);
    exp_dr = mutev ? 0 : clampS(((ar >>> 7) * mvr) >>> 7);
    exp_el = clampS(((el >>> 7) * evl) >>> 7);
    exp_er = clampS(((er >>> 7) * evr) >>> 7);
  endtask

  task automatic clearInputs();
    for (int v = 0; v < NV; v++) begin
      s[v] = 0; vl[v] = 0; vr[v] = 0;
    end
    mvl = 127; mvr = 127; evl = 127; evr = 127;
    eonv = '0; mutev = 1'b0;
  endtask

  // Drive the bus from the stimulus arrays and refresh the model.
  task automatic applyStimulus();
    for (int v = 0; v < NV; v++) begin
      bus.voice_sample[v*SW +: SW] = SW'(s[v]);
      bus.voice_vol_l[v*VLW +: VLW] = VLW'(vl[v]);
      bus.voice_vol_r[v*VLW +: VLW] = VLW'(vr[v]);
    end
    bus.main_vol_l = VLW'(mvl);
    bus.main_vol_r = VLW'(mvr);
    bus.echo_vol_l = VLW'(evl);
    bus.echo_vol_r = VLW'(evr);
    bus.eon = eonv;
    bus.mute = mutev;
    computeModel();
  endtask

  task automatic check(string tag, int obs, int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(string tag, int edl, int edr, int eel, int eer);
    check({tag, ".dac_l"}, int'(bus.dac_out_l), edl);
    check({tag, ".dac_r"}, int'(bus.dac_out_r), edr);
    check({tag, ".echo_l"}, int'(bus.echo_out_l), eel);
    check({tag, ".echo_r"}, int'(bus.echo_out_r), eer);
  endtask

  // Counts falling edges until the strobe is seen; -1 on timeout.
  task automatic waitStrobe(output int cnt);
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (bus.sample_strobe !== 1'b1 && cnt < 200);
    if (bus.sample_strobe !== 1'b1) cnt = -1;
  endtask

  initial begin
    $display("[TB] start");
    clearInputs();
    applyStimulus();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset", 0, 0, 0, 0);
    check("reset.strobe", int'(bus.sample_strobe), 0);
    check("reset.busy", int'(bus.busy), 0);

    // Single voice, first strobe latency and period
    clearInputs();
    s[0] = 1000; vl[0] = 64; vr[0] = 64;
    applyStimulus();
    reset = 1'b0;
    waitStrobe(n);
    check("single.latency", n, 11);
    checkOutput("single", 496, 496, 0, 0);
    check("single.busy_idle", int'(bus.busy), 0);
    @(negedge clock);
    check("single.strobe_one_cycle", int'(bus.sample_strobe), 0);
    waitStrobe(n);
    check("single.period", n, 63);
    checkOutput("single.repeat", 496, 496, 0, 0);

    // Positive saturation
    for (int v = 0; v < NV; v++) begin
      s[v] = 32767; vl[v] = 127; vr[v] = 127;
    end
    eonv = 8'hFF;
    applyStimulus();
    waitStrobe(n);
    check("satpos.period", n, 64);
    checkOutput("satpos", 32767, 32767, 32767, 32767);

    // Negative saturation
    for (int v = 0; v < NV; v++) s[v] = -32768;
    applyStimulus();
    waitStrobe(n);
    check("satneg.period", n, 64);
    checkOutput("satneg", -32768, -32768, -32768, -32768);

    // Echo gating
    clearInputs();
    s[0] = 1000; vl[0] = 64; vr[0] = 64;
    s[1] = 1000; vl[1] = 64; vr[1] = 64;
    eonv = 8'h01;
    applyStimulus();
    waitStrobe(n);
    check("echo.period", n, 64);
    checkOutput("echo", 992, 992, 496, 496);

    // Mute: main silenced, echo unaffected, strobe still pulses
    mutev = 1'b1;
    applyStimulus();
    waitStrobe(n);
    check("mute.period", n, 64);
    checkOutput("mute", 0, 0, 496, 496);

    // Snapshot: voice0 changes at phase 3 of a sample
    clearInputs();
    s[0] = 1000; vl[0] = 64; vr[0] = 64;
    eonv = 8'h01;
    applyStimulus();
    waitStrobe(n);
    checkOutput("snap.base", 496, 496, 496, 496);
    repeat (56) @(negedge clock);
    s[0] = -1000;
    bus.voice_sample[0 +: SW] = SW'(s[0]);
    waitStrobe(n);
    check("snap.latency", n, 8);
    checkOutput("snap.old", 496, 496, 496, 496);
    waitStrobe(n);
    check("snap.period", n, 64);
    checkOutput("snap.new", -497, -497, -497, -497);

    // Reset in the middle of accumulation (phase 4)
    repeat (57) @(negedge clock);
    check("rstmid.busy", int'(bus.busy), 1);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("rstmid.no_strobe", int'(bus.sample_strobe), 0);
    end
    checkOutput("rstmid", 0, 0, 0, 0);
    check("rstmid.busy_clr", int'(bus.busy), 0);
    reset = 1'b0;
    waitStrobe(n);
    check("rstmid.latency", n, 11);
    checkOutput("rstmid.after", -497, -497, -497, -497);

    // Random mixes against the model
    for (int it = 0; it < 8; it++) begin
      for (int v = 0; v < NV; v++) begin
        s[v]  = int'($urandom_range(0, 65535)) - 32768;
        vl[v] = int'($urandom_range(0, 255)) - 128;
        vr[v] = int'($urandom_range(0, 255)) - 128;
      end
      mvl = int'($urandom_range(0, 255)) - 128;
      mvr = int'($urandom_range(0, 255)) - 128;
      evl = int'($urandom_range(0, 255)) - 128;
      evr = int'($urandom_range(0, 255)) - 128;
      eonv = NV'($urandom);
      mutev = 1'($urandom_range(0, 3) == 0);
      applyStimulus();
      waitStrobe(n);
      check("rand.period", n, 64);
      checkOutput("rand", exp_dl, exp_dr, exp_el, exp_er);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
